// File: rtl/tdm_receive_multi.sv
// TDM deserialiser: captures SLOTS x BIT_WIDTH samples per frame and publishes them as one word with a valid pulse.
// Publishes on the posedge that samples the last sample bit of the last slot; no back-pressure, the word holds until the next publish.
module tdm_receive_multi #(
    parameter int BIT_WIDTH  = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int SLOTS      = 8,
    parameter int WS_DELAY   = 1
) (
    input  logic                                          sck,
    input  logic                                          rst_n_in,
    input  logic                                          ws,
    input  logic                                          sd,
    output logic [SLOTS*BIT_WIDTH-1:0]                    audio_out,
    output logic                                          audio_valid_out,
    output logic [((SLOTS > 1) ? $clog2(SLOTS) : 1)-1:0]  slot_out,
    output logic                                          locked_out,
    output logic                                          frame_err_out
);
    localparam int SLW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int BCW = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
    localparam int AW  = SLOTS * BIT_WIDTH;
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(SLOT_WIDTH - 1);
    localparam logic [BCW-1:0] SMP_LAST  = BCW'(BIT_WIDTH - 1);
    localparam logic [SLW-1:0] SLOT_LAST = SLW'(SLOTS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic           ws_q;
    logic [BCW-1:0] bit_q, bit_d, eff_bit;
    logic [SLW-1:0] slot_q, slot_d, eff_slot;
    logic [AW-1:0]  work_q, work_d;
    logic           ws_rise, run, exp_cyc, unexp, missing, sync_ok, restart;
    logic           cap, clr_first, clr_after, publish, sync_err;

    always_comb begin
        ws_rise   = ws & ~ws_q;
        run       = (state_q == RUN);
        if (WS_DELAY != 0) begin
            exp_cyc = (bit_q == BIT_LAST) && (slot_q == SLOT_LAST);
        end else begin
            exp_cyc = (bit_q == '0) && (slot_q == '0);
        end
        unexp     = run && ws_rise && !exp_cyc;
        missing   = run && !ws_rise && exp_cyc;
        sync_ok   = run && ws_rise && exp_cyc;
        restart   = ws_rise && (!run || !exp_cyc);
        sync_err  = unexp || missing;
        eff_bit   = bit_q;
        eff_slot  = slot_q;
        // With zero-delay sync the rise cycle itself is pos 0 of the new frame.
        if (WS_DELAY != 0) begin
            cap       = run && !unexp;
            clr_first = 1'b0;
            clr_after = restart || sync_ok;
        end else begin
            cap       = restart || (run && !sync_err);
            clr_first = restart || sync_ok;
            clr_after = 1'b0;
            if (restart) begin
                eff_bit  = '0;
                eff_slot = '0;
            end
        end

        work_d = clr_first ? '0 : work_q;
        if (cap && (eff_bit <= SMP_LAST)) begin
            for (int k = 0; k < SLOTS; k++) begin
                if (eff_slot == SLW'(k)) begin
                    work_d[k*BIT_WIDTH +: BIT_WIDTH] =
                        (work_d[k*BIT_WIDTH +: BIT_WIDTH] << 1) | BIT_WIDTH'(sd);
                end
            end
        end
        publish = cap && (eff_bit == SMP_LAST) && (eff_slot == SLOT_LAST);

        bit_d  = '0;
        slot_d = '0;
        if (cap && !missing) begin
            if (eff_bit == BIT_LAST) begin
                slot_d = (eff_slot == SLOT_LAST) ? '0 : eff_slot + SLW'(1);
            end else begin
                bit_d  = eff_bit + BCW'(1);
                slot_d = eff_slot;
            end
        end

        state_d = state_q;
        if (!run && ws_rise) begin
            state_d = RUN;
        end else if (missing) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge sck or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q         <= IDLE;
            ws_q            <= 1'b0;
            bit_q           <= '0;
            slot_q          <= '0;
            work_q          <= '0;
            audio_out       <= '0;
            audio_valid_out <= 1'b0;
            locked_out      <= 1'b0;
            frame_err_out   <= 1'b0;
        end else begin
            state_q         <= state_d;
            ws_q            <= ws;
            bit_q           <= bit_d;
            slot_q          <= slot_d;
            work_q          <= clr_after ? '0 : work_d;
            audio_valid_out <= publish;
            frame_err_out   <= sync_err;
            if (publish) begin
                audio_out <= work_d;
            end
            if (sync_err) begin
                locked_out <= 1'b0;
            end else if (publish) begin
                locked_out <= 1'b1;
            end
        end
    end

    assign slot_out = run ? slot_q : '0;

endmodule

// File: doc/tdm_receive_multi.md
# tdm_receive_multi

Parametrised TDM serial-audio deserialiser that sits directly behind the microphone-array pins and feeds the beamforming datapath. It generalises our TDM receive path to any slot count, slot width and sample width, and supports both I2S-style one-bit-delayed and zero-delay frame sync. It publishes all slots of a frame as one packed word with a single valid pulse. It also tracks frame lock and flags sync errors instead of silently misaligning.

## Interface

Reset is asynchronous, active-low (`rst_n_in`); the block runs on the single clock `sck`.

Parameters:
- BIT_WIDTH, 24, sample bits captured per slot, MSB first; 1 ≤ BIT_WIDTH ≤ SLOT_WIDTH
- SLOT_WIDTH, 32, sck cycles per slot; bits after BIT_WIDTH are padding and are ignored
- SLOTS, 8, slots per frame; ≥ 1
- WS_DELAY, 1, 1 = slot-0 MSB on the cycle after the ws rise; 0 = slot-0 MSB on the ws-rise cycle

Ports:
- sck  in  1  serial bit clock, all logic on posedge
- rst_n_in  in  1  asynchronous active-low reset
- ws  in  1  frame sync; only its rising edge is significant
- sd  in  1  serial data
- audio_out  out  SLOTS*BIT_WIDTH  packed samples; slot k at [k*BIT_WIDTH +: BIT_WIDTH]
- audio_valid_out  out  1  one-cycle pulse when audio_out has been updated
- slot_out  out  $clog2(SLOTS) (min 1)  slot index of the bit sampled this cycle; 0 when unlocked
- locked_out  out  1  high after the first published frame; cleared on any sync error
- frame_err_out  out  1  one-cycle pulse on a sync error

## Operation

- N = SLOTS*SLOT_WIDTH. P = (SLOTS-1)*SLOT_WIDTH + BIT_WIDTH-1 is the publish position.
- ws_q is a registered copy of ws, reset 0. ws_rise = ws & ~ws_q. Therefore ws held high through reset counts as a rise on the first cycle.
- Frame position pos counts 0..N-1. Internally it is held as bit-in-slot and slot counters, so non-power-of-2 widths are legal.
- States:
  - IDLE: sd ignored, pos held at 0.
    - ws_rise with WS_DELAY=1: go to RUN; the next cycle is pos 0.
    - ws_rise with WS_DELAY=0: go to RUN; this cycle is pos 0, so sd is captured now.
  - RUN, each cycle:
    - If bit-in-slot < BIT_WIDTH, shift sd into the working shift register of the current slot.
    - Increment pos, wrapping N-1 → 0.
- Expected sync cycle: pos == N-1 for WS_DELAY=1. For WS_DELAY=0 it is the wrap cycle, i.e. pos 0 of the following frame.
- Publish: on the sample at pos P, load all working registers, including the bit sampled this cycle, into audio_out. Pulse audio_valid_out and set locked_out.
- Sync checks in RUN:
  - ws_rise exactly on the expected cycle: normal continuation.
  - ws_rise on any other cycle (unexpected sync):
    - Pulse frame_err_out and clear locked_out.
    - Discard the partial frame; no publish.
    - Restart alignment from this rise, as on entry from IDLE; stay in RUN.
  - No ws_rise on the expected cycle (missing sync):
    - Pulse frame_err_out, clear locked_out, go to IDLE.
    - A frame already published is not retracted. For WS_DELAY=1 with P == N-1, the publish still occurs on that cycle.
- An unexpected ws_rise after P but before the expected cycle: error and restart only; the frame remains published.
- audio_out holds its value between publishes. It is never cleared except by reset.
- Working shift registers are cleared on every frame start.

## Timing

- Reset values: audio_out 0, audio_valid_out 0, slot_out 0, locked_out 0, frame_err_out 0, ws_q 0, state IDLE.
- Reset is asynchronous assert and synchronous-safe deassert. Reset mid-frame drops the frame and requires a new ws_rise.
- Publish latency:
  - audio_out and audio_valid_out change at the posedge that samples the bit at pos P, and are visible for the following cycle.
  - For WS_DELAY=1 this is posedge P+1 counted from the cycle after the ws rise.
- slot_out is combinational from the slot counter (the slot of the current sample) and 0 in IDLE.
- frame_err_out and locked_out are registered, changing at the posedge of the offending cycle.
- No back-pressure: the consumer must accept audio_out within N cycles.

## Test plan

- Defaults (24/32/8/1): ws pulses every 256 cycles; slot k carries 24'h100000+k MSB-first plus 8 padding bits of 1 → one valid pulse per frame. audio_out slot k equals 24'h100000+k, padding is absent, and locked_out rises with the first pulse.
- WS_DELAY=0, SLOTS=4: ws rises on the MSB cycle of slot 0 with samples 24'hABCDEF, 24'h123456, 24'h000001, 24'hFFFFFF → all four captured exactly; frame_err_out stays 0 over 10 frames.
- Unexpected sync: ws rise at pos 100 of a locked frame → frame_err_out one cycle, locked_out 0, and no valid for that frame. The next frame, aligned to the new rise, publishes correctly.
- Missing sync: ws stuck low after 2 good frames → the 2nd frame is published, frame_err_out pulses at pos 255, and the block is in IDLE with slot_out 0. A later ws rise relocks.
- Reset mid-frame: rst_n_in low at pos 50 → all outputs 0 immediately (asynchronously). No valid until a new ws rise plus 248 cycles.
- Non-power-of-2 (BIT_WIDTH=16, SLOT_WIDTH=20, SLOTS=3): 60-cycle frames → correct packing into 48 bits, and slot_out sequence 0,1,2 with 20 cycles each.
